// File: rtl/instr_fetch_stage_pkg.sv
// Shared widths, state encodings and entry layout for the instruction fetch stage.
// Optional misaligned-redirect trap is enabled in the top by defining FETCH_MISALIGN_CHECK_EN.
package instr_fetch_stage_pkg;

  localparam int DATA_BUS_BITS  = 64;
  localparam int INSTR_BUS_BITS = 32;

  localparam logic [DATA_BUS_BITS-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'b00,
    FETCH_DRAIN = 2'b01,
    FETCH_HALT  = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_BUS_BITS-1:0] instr;
    logic [DATA_BUS_BITS-1:0]  pc;
    logic [DATA_BUS_BITS-1:0]  pc_plus4;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_BITS = $bits(fetch_entry_t);

  // Sequential successor; wraps modulo 2^64.
  function automatic logic [DATA_BUS_BITS-1:0] next_seq_pc(input logic [DATA_BUS_BITS-1:0] pc);
    return pc + DATA_BUS_BITS'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_fetch_fifo.sv
// Small synchronous FIFO with flush; used for the in-flight PC queue and the response buffer.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign push_ok = push & (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, issues in-order imem fetches under a credit limit, buffers responses for IF/ID,
// and drains stale responses after a redirect. FETCH_MISALIGN_CHECK_EN adds a HALT trap on misaligned targets.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [DATA_BUS_BITS-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                       FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      imem_req,
  output logic [DATA_BUS_BITS-1:0]  imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [INSTR_BUS_BITS-1:0] imem_rdata,
  input  logic                      redirect_valid,
  input  logic [DATA_BUS_BITS-1:0]  redirect_pc,
  input  logic                      id_ready,
  output logic                      if_valid,
  output logic [INSTR_BUS_BITS-1:0] instr_out,
  output logic [DATA_BUS_BITS-1:0]  PC_out,
  output logic [DATA_BUS_BITS-1:0]  PCPlus4_out,
  output logic                      fetch_misaligned
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e              state_q, state_d;
  logic [DATA_BUS_BITS-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]          drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]          inflight_cnt;
  logic [CNT_W-1:0]          rsp_cnt;
  logic                      inflight_empty;
  logic                      rsp_empty;
  logic [DATA_BUS_BITS-1:0]  inflight_pc;
  fetch_entry_t              rsp_head;
  fetch_entry_t              rsp_push_entry;

  logic [CNT_W-1:0]          outstanding;
  logic [CNT_W:0]            credits_used;
  logic                      credit_ok;
  logic                      fetch_hs;
  logic                      rsp_accept;
  logic                      rvalid_live;
  logic                      out_pop;
  logic [DATA_BUS_BITS-1:0]  redirect_target;
  logic                      redirect_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misaligned_q, fetch_misaligned_d;

  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[DATA_BUS_BITS-1:2], 2'b00};
  assign redirect_misaligned  = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // Only one of the two terms is ever nonzero: the PC queue is empty outside RUN, drop_cnt is zero in RUN.
  assign outstanding = inflight_cnt + drop_cnt_q;
  assign rvalid_live = imem_rvalid & (outstanding != '0);
  assign out_pop     = if_valid & id_ready;

  // A head leaving this cycle frees its slot immediately, which keeps a 1-cycle memory streaming without bubbles.
  assign credits_used = {1'b0, inflight_cnt} + {1'b0, rsp_cnt} - (CNT_W + 1)'(out_pop);
  assign credit_ok    = credits_used < (CNT_W + 1)'(FIFO_DEPTH);

  assign imem_req   = reset_n & (state_q == FETCH_RUN) & ~redirect_valid & credit_ok;
  assign imem_addr  = pc_q;
  assign fetch_hs   = imem_req & imem_gnt;
  assign rsp_accept = (state_q == FETCH_RUN) & ~redirect_valid & imem_rvalid & ~inflight_empty;

  assign rsp_push_entry = '{instr: imem_rdata, pc: inflight_pc, pc_plus4: next_seq_pc(inflight_pc)};

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    pc_d       = pc_q;
    if (redirect_valid) begin
      pc_d       = redirect_target;
      drop_cnt_d = outstanding - CNT_W'(rvalid_live);
      if (redirect_misaligned) begin
        state_d = FETCH_HALT;
      end else if (drop_cnt_d != '0) begin
        state_d = FETCH_DRAIN;
      end else begin
        state_d = FETCH_RUN;
      end
    end else begin
      if (fetch_hs) begin
        pc_d = next_seq_pc(pc_q);
      end
      case (state_q)
        FETCH_RUN: begin
        end
        FETCH_DRAIN: begin
          if (rvalid_live) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
            if (drop_cnt_q == CNT_W'(1)) begin
              state_d = FETCH_RUN;
            end
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        FETCH_HALT: begin
          if (rvalid_live) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
          end
        end
`endif
        default: begin
          state_d = FETCH_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    fetch_misaligned_d = fetch_misaligned_q;
    if (redirect_valid) begin
      fetch_misaligned_d = redirect_misaligned;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_misaligned_q <= 1'b0;
    end else begin
      fetch_misaligned_q <= fetch_misaligned_d;
    end
  end

  assign fetch_misaligned = fetch_misaligned_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

  fetch_fifo #(
    .WIDTH (DATA_BUS_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_inflight_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (fetch_hs),
    .push_data (pc_q),
    .pop       (rsp_accept),
    .head_data (inflight_pc),
    .empty     (inflight_empty),
    .count     (inflight_cnt)
  );

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (rsp_accept),
    .push_data (rsp_push_entry),
    .pop       (out_pop),
    .head_data (rsp_head),
    .empty     (rsp_empty),
    .count     (rsp_cnt)
  );

  // The buffer head keeps stale data after a pop, so the payload is forced to zero when empty.
  assign if_valid    = ~rsp_empty & ~redirect_valid;
  assign instr_out   = rsp_empty ? '0 : rsp_head.instr;
  assign PC_out      = rsp_empty ? '0 : rsp_head.pc;
  assign PCPlus4_out = rsp_empty ? '0 : rsp_head.pc_plus4;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a queued imem model with configurable latency feeds the DUT,
// every accepted fetch pushes its expected IF/ID entry, and each IF/ID transfer pops and compares it.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] instr_out;
  logic [63:0] PC_out;
  logic [63:0] PCPlus4_out;
  logic        fetch_misaligned;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic        w_if_valid;
  logic [31:0] w_instr;
  logic [63:0] w_pc;
  logic [63:0] w_pcp4;
  logic        w_misaligned;
  logic        w_hs = 1'b0;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pcp4;
  } exp_t;

  mem_req_t    pend[$];
  exp_t        sb[$];
  int          mem_lat = 1;
  int          cyc = 0;
  logic        mem_hs = 1'b0;
  logic        mem_take = 1'b0;
  logic [63:0] mem_hs_addr = '0;
  logic [63:0] exp_pc = '0;
  int          hs_count = 0;
  int          n_out = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          base;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_ready         (id_ready),
    .if_valid         (if_valid),
    .instr_out        (instr_out),
    .PC_out           (PC_out),
    .PCPlus4_out      (PCPlus4_out),
    .fetch_misaligned (fetch_misaligned)
  );

  instr_fetch_stage #(
    .RESET_PC   (64'hFFFF_FFFF_FFFF_FFFC),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_req         (w_req),
    .imem_addr        (w_addr),
    .imem_gnt         (1'b1),
    .imem_rvalid      (w_rvalid),
    .imem_rdata       (32'h0000_0013),
    .redirect_valid   (1'b0),
    .redirect_pc      (64'h0),
    .id_ready         (1'b1),
    .if_valid         (w_if_valid),
    .instr_out        (w_instr),
    .PC_out           (w_pc),
    .PCPlus4_out      (w_pcp4),
    .fetch_misaligned (w_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] redirect_expect(input logic [63:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
    return p;
`else
    return {p[63:2], 2'b00};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] pc);
    @(posedge clk);
    #1;
    redirect_valid = rv;
    redirect_pc    = pc;
  endtask

  task automatic applyReset(input int lat, input logic rdy);
    @(posedge clk);
    #1;
    reset_n        = 1'b0;
    mem_lat        = lat;
    id_ready       = rdy;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Memory model: requests answered strictly in order, mem_lat cycles after the grant edge.
  always @(negedge clk) begin
    mem_hs      = imem_req & imem_gnt;
    mem_hs_addr = imem_addr;
    mem_take    = imem_rvalid;
    w_hs        = w_req;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    w_rvalid = reset_n & w_hs;
    if (!reset_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (mem_take && pend.size() > 0) begin
        void'(pend.pop_front());
      end
      if (mem_hs) begin
        pend.push_back('{addr: mem_hs_addr, due: cyc + mem_lat - 1});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Scoreboard: expected PC stream tracked independently, compared on every IF/ID transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      exp_pc   = 64'h0;
      hs_count = 0;
    end else begin
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_expect(redirect_pc);
      end else if (imem_req && imem_gnt) begin
        checkOutput("fetch_addr", imem_addr, exp_pc);
        sb.push_back('{instr: mem_word(exp_pc), pc: exp_pc, pcp4: exp_pc + 64'd4});
        exp_pc = exp_pc + 64'd4;
        hs_count++;
      end
      if (if_valid && id_ready) begin
        if (sb.size() == 0) begin
          checkOutput("stray_valid", 64'(if_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("instr_out", 64'(instr_out), 64'(e.instr));
          checkOutput("PC_out", PC_out, e.pc);
          checkOutput("PCPlus4_out", PCPlus4_out, e.pcp4);
          n_out++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    imem_gnt       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 1;

    repeat (2) @(negedge clk);
    checkOutput("rst_imem_req", 64'(imem_req), 64'd0);
    checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
    checkOutput("rst_instr_out", 64'(instr_out), 64'd0);
    checkOutput("rst_PC_out", PC_out, 64'd0);
    checkOutput("rst_PCPlus4_out", PCPlus4_out, 64'd0);
    checkOutput("rst_misaligned", 64'(fetch_misaligned), 64'd0);

    // Streaming with a 1-cycle memory: one instruction per cycle once the pipe fills.
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("t1_no_bubble", 64'(if_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("t1_outputs_seen", 64'(n_out >= 8), 64'd1);

    // IF/ID stalled: the credit limit allows exactly FIFO_DEPTH fetches.
    applyReset(1, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("t2_handshakes", 64'(hs_count), 64'd2);
    checkOutput("t2_req_stalled", 64'(imem_req), 64'd0);
    base = n_out;
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t2_drained", 64'(n_out - base >= 3), 64'd1);

    // 3-cycle memory, redirect with two fetches in flight: both responses dropped.
    applyReset(3, 1'b1);
    @(posedge clk);
    applyStimulus(1'b1, 64'h100);
    @(negedge clk);
    checkOutput("t3_redirect_valid", 64'(if_valid), 64'd0);
    checkOutput("t3_redirect_req", 64'(imem_req), 64'd0);
    applyStimulus(1'b0, 64'h0);
    @(negedge clk);
    checkOutput("t3_drain_req_a", 64'(imem_req), 64'd0);
    @(negedge clk);
    checkOutput("t3_drain_req_b", 64'(imem_req), 64'd0);
    @(negedge clk);
    checkOutput("t3_resume_req", 64'(imem_req), 64'd1);
    checkOutput("t3_resume_addr", imem_addr, 64'h100);
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t3_target_seen", 64'(n_out - base >= 1), 64'd1);

    // Redirect in the same cycle as a response and a ready head.
    applyReset(1, 1'b1);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 64'h300);
    @(negedge clk);
    checkOutput("t4_if_valid_redirect", 64'(if_valid), 64'd0);
    applyStimulus(1'b0, 64'h0);
    @(negedge clk);
    checkOutput("t4_empty_valid", 64'(if_valid), 64'd0);
    checkOutput("t4_empty_instr", 64'(instr_out), 64'd0);
    checkOutput("t4_empty_pc", PC_out, 64'd0);
    checkOutput("t4_empty_pcp4", PCPlus4_out, 64'd0);
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t4_resumed", 64'(n_out - base >= 3), 64'd1);

    // PC wrap from the top of the address space.
    applyReset(1, 1'b1);
    @(negedge clk);
    checkOutput("t5_first_req", 64'(w_req), 64'd1);
    checkOutput("t5_first_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    checkOutput("t5_second_addr", w_addr, 64'h0);
    @(negedge clk);
    checkOutput("t5_if_valid", 64'(w_if_valid), 64'd1);
    checkOutput("t5_pc_out", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("t5_pcp4_wrap", w_pcp4, 64'h0);

    // Misaligned redirect target.
    applyReset(1, 1'b1);
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 64'h102);
    applyStimulus(1'b0, 64'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    checkOutput("t6_misaligned_set", 64'(fetch_misaligned), 64'd1);
    checkOutput("t6_halt_req", 64'(imem_req), 64'd0);
    checkOutput("t6_halt_valid", 64'(if_valid), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("t6_halt_req_hold", 64'(imem_req), 64'd0);
    checkOutput("t6_misaligned_hold", 64'(fetch_misaligned), 64'd1);
    applyStimulus(1'b1, 64'h200);
    applyStimulus(1'b0, 64'h0);
    @(negedge clk);
    checkOutput("t6_misaligned_clr", 64'(fetch_misaligned), 64'd0);
    checkOutput("t6_resume_req", 64'(imem_req), 64'd1);
    checkOutput("t6_resume_addr", imem_addr, 64'h200);
`else
    @(negedge clk);
    checkOutput("t6_misaligned_tied", 64'(fetch_misaligned), 64'd0);
    checkOutput("t6_aligned_req", 64'(imem_req), 64'd1);
    checkOutput("t6_aligned_addr", imem_addr, 64'h100);
`endif
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t6_resumed", 64'(n_out - base >= 3), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
